// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-stream loader with a combinational read port for the lookup memory
// Optional running XOR checksum on csum when ROM_LOADER_CSUM_EN is defined.
module rom_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] csum
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   len_eff;
  logic              xfer;

  // A length of zero means a full-depth load; anything beyond DEPTH is clamped.
  always_comb begin
    len_eff = load_len;
    if (load_len == '0 || load_len > DEPTH_L) len_eff = DEPTH_L;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    wr_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    xfer     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = start_addr;
          rem_d   = len_eff;
        end
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        // Abort wins over a coincident byte: nothing is written on the abort edge.
        if (abort) begin
          state_d = S_IDLE;
        end else if (wr_valid) begin
          xfer  = 1'b1;
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == ONE_L) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (xfer) begin
      mem_q[ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

`ifdef ROM_LOADER_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              start_ok;

  assign start_ok = (state_q == S_IDLE) && start;

  always_comb begin
    csum_d = csum_q;
    if (start_ok)  csum_d = '0;
    else if (xfer) csum_d = csum_q ^ wr_data;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) csum_q <= '0;
    else             csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - randomized self-checking bench for rom_loader against a load-level memory model
module tb_rom_loader;
  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] load_len;
  logic       abort;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] csum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_mem [8];
  logic [7:0] m_csum;

  always #5 clk = ~clk;

  rom_loader dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .start     (start),
    .start_addr(start_addr),
    .load_len  (load_len),
    .abort     (abort),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .csum      (csum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_csum();
`ifdef ROM_LOADER_CSUM_EN
    return m_csum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_csum = 8'h00;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      check($sformatf("%s[%0d]", tag, a), rd_data, m_mem[a]);
    end
  endtask

  // One load: model writes byte n of the load to (sa + n) mod 8, up to the effective length.
  task automatic run_load(input logic [2:0] sa, input logic [3:0] len, input int abort_at,
                          input bit vrand, input logic [31:0] vmask,
                          input bit drand, input logic [7:0] dbase, input logic [7:0] dstep,
                          input bit noise);
    int         eff, n, cyc;
    bit         v, ab;
    logic [7:0] d;
    eff = (len == 0 || len > 8) ? 8 : int'(len);
    @(negedge clk);
    start = 1'b1; start_addr = sa; load_len = len;
    @(negedge clk);
    m_csum = 8'h00;
    n = 0; cyc = 0; ab = 1'b0;
    while (n < eff && cyc < 200) begin
      check("busy_load", busy, 1);
      check("ready_load", wr_ready, 1);
      check("done_load", done, 0);
      v  = vrand ? 1'($urandom_range(0, 1)) : vmask[cyc % 32];
      d  = drand ? 8'($urandom) : 8'(dbase + dstep * 8'(n));
      ab = (n == abort_at) && v;
      start      = noise && (cyc == 1);
      start_addr = 3'($urandom);
      load_len   = 4'($urandom);
      wr_valid = v; wr_data = d; abort = ab;
      @(negedge clk);
      if (ab) break;
      if (v) begin
        m_mem[(int'(sa) + n) % 8] = d;
        m_csum ^= d;
        n++;
      end
      cyc++;
    end
    wr_valid = 1'b0; abort = 1'b0; start = 1'b0;
    if (ab) begin
      check("abort_ready_fall", wr_ready, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
    end else begin
      check("load_bound", cyc < 200, 1);
      check("done_pulse", done, 1);
      check("done_ready", wr_ready, 0);
      check("done_busy", busy, 0);
      start = 1'b1; start_addr = 3'($urandom);
      @(negedge clk);
      start = 1'b0;
      check("done_once", done, 0);
      check("idle_busy", busy, 0);
    end
    @(negedge clk);
    check("still_idle", busy, 0);
    check("idle_ready", wr_ready, 0);
    check("csum", csum, exp_csum());
    check_mem("mem");
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; start_addr = '0; load_len = '0; abort = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_csum", csum, 0);
    rstn = 1'b1;
    check_mem("rst_mem");

    run_load(3'd0, 4'd0, -1, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'h11, 8'h11, 1'b0);
    run_load(3'd6, 4'd4, -1, 1'b0, 32'h0000_0035, 1'b0, 8'hA0, 8'h01, 1'b0);
    run_load(3'd3, 4'd5, 2, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'hC0, 8'h01, 1'b0);
    run_load(3'd5, 4'd3, -1, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'h50, 8'h03, 1'b1);
    run_load(3'd2, 4'd12, -1, 1'b0, 32'h5555_5555, 1'b0, 8'h07, 8'h09, 1'b0);

    for (int k = 0; k < 25; k++) begin
      run_load(3'($urandom), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
               1'b1, 32'h0, 1'b1, 8'h00, 8'h00, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    start = 1'b1; start_addr = 3'd2; load_len = 4'd6;
    @(negedge clk);
    start = 1'b0; wr_valid = 1'b1; wr_data = 8'h5A;
    repeat (3) @(negedge clk);
    rd_addr = 3'd2;
    #1;
    check("midload_written", rd_data, 8'h5A);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", wr_ready, 0);
    check("arst_done", done, 0);
    check("arst_csum", csum, 0);
    check("arst_rd", rd_data, 8'h00);
    wr_valid = 1'b0;
    model_reset();
    check_mem("arst_mem");
    @(negedge clk);
    #2;
    rstn = 1'b1;
    run_load(3'd7, 4'd3, -1, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'h31, 8'h10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
